// File: rtl/bch_pkg.sv
// Shared definitions for the parallel DVB-S2 BCH encoder.
// Contents:
//   - tsel_t   : run-time correction capability encodings (t = 8/10/12).
//   - state_t  : FSM states of the encoder top.
//   - G_T8/G_T10/G_T12 : generator polynomials. Each is the product of the
//     normal-frame minimal polynomials g1..gt over GF(2). Bit i holds the
//     coefficient of x^i.
//   - tsel_to_r   : parity length R selected by a t_sel code.
//   - lfsr_step_w : w-step unrolled remainder update, first bit = data MSB.
package bch_pkg;

  typedef enum logic [1:0] {
    TSEL_T8   = 2'd0,
    TSEL_T10  = 2'd1,
    TSEL_T12  = 2'd2,
    TSEL_RSVD = 2'd3
  } tsel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Degree-16 minimal polynomials g1..g12 of the normal FECFRAME code.
  function automatic logic [16:0] min_poly(input int j);
    case (j)
      1:       return 17'h1002D;
      2:       return 17'h10173;
      3:       return 17'h10FBD;
      4:       return 17'h15A55;
      5:       return 17'h11F2F;
      6:       return 17'h1F7B5;
      7:       return 17'h1AF65;
      8:       return 17'h17367;
      9:       return 17'h10EA1;
      10:      return 17'h175A7;
      11:      return 17'h13A2D;
      12:      return 17'h11AE3;
      default: return 17'h00001;
    endcase
  endfunction

  // Carry-less product g1*g2*...*gt; degree 16*t.
  function automatic logic [192:0] bch_gen(input int t);
    logic [192:0] g;
    logic [192:0] prod;
    logic [16:0]  m;
    g = 193'd1;
    for (int j = 1; j <= 12; j++) begin
      if (j <= t) begin
        m    = min_poly(j);
        prod = '0;
        for (int k = 0; k < 17; k++) begin
          if (m[k]) prod = prod ^ (g << k);
        end
        g = prod;
      end
    end
    return g;
  endfunction

  localparam logic [128:0] G_T8  = 129'(bch_gen(8));
  localparam logic [160:0] G_T10 = 161'(bch_gen(10));
  localparam logic [192:0] G_T12 = bch_gen(12);

  // The reserved code behaves as t=12.
  function automatic logic [7:0] tsel_to_r(input logic [1:0] t);
    case (t)
      TSEL_T8:  return 8'd128;
      TSEL_T10: return 8'd160;
      default:  return 8'd192;
    endcase
  endfunction

  // Advances the remainder register by w message bits. data holds the bits
  // right-aligned (data[w-1] first in time). Only the low r bits are live;
  // the mask keeps everything above r at zero so a shorter code can share
  // the full-width register.
  function automatic logic [191:0] lfsr_step_w(input logic [191:0] state,
                                               input logic [31:0]  data,
                                               input logic [192:0] poly,
                                               input int           r,
                                               input int           w);
    logic [191:0] s;
    logic [191:0] mask;
    logic [31:0]  d;
    logic         fb;
    s    = state;
    mask = {192{1'b1}} >> (192 - r);
    d    = data << (32 - w);
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        fb = d[31 - i] ^ s[r - 1];
        s  = (s << 1) & mask;
        if (fb) s = s ^ (poly[191:0] & mask);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/bch_lfsr_par.sv
// Parallel BCH remainder register.
// Ports:
//   clk, reset : clock and synchronous active-low reset
//   clr        : zero the register (frame start)
//   en         : absorb one W-bit message word
//   din        : message word, din[W-1] first in time
//   poly       : generator polynomial of the active code
//   r          : active parity length (128/160/192)
//   state      : current remainder, bits at and above r held zero
module bch_lfsr_par
  import bch_pkg::*;
#(
  parameter int W    = 8,
  parameter int PMAX = 192
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [W-1:0]    din,
  input  logic [PMAX:0]   poly,
  input  logic [7:0]      r,
  output logic [PMAX-1:0] state
);

  // Remainder register: cleared per frame, advanced once per accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= '0;
    end else if (clr) begin
      state <= '0;
    end else if (en) begin
      state <= lfsr_step_w(state, 32'(din), poly, int'(r), W);
    end
  end

endmodule

// File: rtl/bch_encoder_par.sv
// W-bit-per-clock DVB-S2 BCH encoder (t = 8/10/12).
// Systematic words are forwarded with dataenable=1, then R/W parity words
// follow with dataenable=0, MSB of the remainder first.
// Ports:
//   CLK, reset             : clock, synchronous active-low reset
//   start, t_sel, k_len    : frame start and its parameters (IDLE only)
//   din/din_valid/din_ready: message input handshake
//   dout/dout_valid/dout_ready, dataenable : codeword output handshake
//   bits        : last frame's parity, right-aligned, held between frames
//   parity_done : pulse after the final parity word is accepted
//   busy        : a frame is in progress
module bch_encoder_par
  import bch_pkg::*;
#(
  parameter int W      = 8,
  parameter int KLEN_W = 16,
  parameter int PMAX   = 192
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        t_sel,
  input  logic [KLEN_W-1:0] k_len,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [W-1:0]      dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dataenable,
  output logic [PMAX-1:0]   bits,
  output logic              parity_done,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [7:0]        r_q;
  logic [KLEN_W-1:0] cnt_q;
  logic [7:0]        idx_q;
  logic [7:0]        nwords;
  logic [PMAX:0]     poly;
  logic [PMAX-1:0]   lfsr_state;
  logic [PMAX-1:0]   shifted;
  logic [W-1:0]      parity_word;
  logic              out_free, take, last_data, start_ok, par_load, par_last;

  // Handshake qualifiers. The output register counts as free when empty or
  // being drained this cycle, which is what lets parity follow data with no
  // bubble.
  always_comb begin
    out_free  = !dout_valid || dout_ready;
    din_ready = (state_q == DATA) && out_free;
    take      = din_valid && din_ready;
    last_data = take && (cnt_q <= KLEN_W'(W));
    start_ok  = (state_q == IDLE) && start;
    nwords    = 8'(int'(r_q) / W);
    par_load  = (state_q == PARITY) && out_free && (idx_q < nwords);
    par_last  = (state_q == PARITY) && dout_valid && dout_ready &&
                !dataenable && (idx_q == nwords);
    busy      = (state_q != IDLE);
  end

  // Generator for the latched code, and the parity word at index idx_q,
  // i.e. lfsr[R-1-idx*W -: W], found by shifting it to the top.
  always_comb begin
    case (r_q)
      8'd128:  poly = (PMAX+1)'(G_T8);
      8'd160:  poly = (PMAX+1)'(G_T10);
      default: poly = (PMAX+1)'(G_T12);
    endcase
    shifted     = lfsr_state << (PMAX - int'(r_q) + int'(idx_q) * W);
    parity_word = shifted[PMAX-1 -: W];
  end

  // Next-state logic. A zero-length frame goes straight to parity so it
  // cannot wait forever for data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_len == '0) ? PARITY : DATA;
      DATA:    if (last_data) state_d = PARITY;
      PARITY:  if (par_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output register, counters and parity capture.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_q         <= 8'd0;
      cnt_q       <= '0;
      idx_q       <= 8'd0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dataenable  <= 1'b0;
      bits        <= '0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= 1'b0;
      if (start_ok) begin
        r_q   <= tsel_to_r(t_sel);
        cnt_q <= k_len;
        idx_q <= 8'd0;
      end
      if (take) begin
        dout       <= din;
        dout_valid <= 1'b1;
        dataenable <= 1'b1;
        cnt_q      <= last_data ? '0 : cnt_q - KLEN_W'(W);
      end else if (par_load) begin
        dout       <= parity_word;
        dout_valid <= 1'b1;
        dataenable <= 1'b0;
        idx_q      <= idx_q + 8'd1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        dataenable <= 1'b0;
      end
      if (par_last) begin
        parity_done <= 1'b1;
        bits        <= lfsr_state;
      end
    end
  end

  bch_lfsr_par #(
    .W    (W),
    .PMAX (PMAX)
  ) u_lfsr (
    .clk   (CLK),
    .reset (reset),
    .clr   (start_ok),
    .en    (take),
    .din   (din),
    .poly  (poly),
    .r     (r_q),
    .state (lfsr_state)
  );

endmodule

// File: tb/tb_bch_encoder_par.sv
// Self-checking bench for bch_encoder_par (W=8). Expected parity comes from
// a long-division model of m(x)*x^R mod g(x), with g built here from the
// minimal polynomials.
module tb_bch_encoder_par;

  localparam int W      = 8;
  localparam int KLEN_W = 16;
  localparam int PMAX   = 192;

  localparam int K_ZERO = 0;
  localparam int K_ONE  = 1;
  localparam int K_RAND = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        t_sel;
  logic [KLEN_W-1:0] k_len;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              din_ready;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dataenable;
  logic [PMAX-1:0]   bits;
  logic              parity_done;
  logic              busy;

  bch_encoder_par #(.W(W), .KLEN_W(KLEN_W), .PMAX(PMAX)) dut (
    .CLK         (clk),
    .reset       (reset),
    .start       (start),
    .t_sel       (t_sel),
    .k_len       (k_len),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dataenable  (dataenable),
    .bits        (bits),
    .parity_done (parity_done),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] tsel;
    int         klen;
    int         kind;
    bit         bursty;
    bit         slow;
    bit         inject;
    int         exp_r;
    int         exp_words;
  } vec_t;

  vec_t       vecs[8];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] msg[$];
  logic [7:0] exp_word[$];
  logic       exp_de[$];

  task automatic checkOutput(input string name, input logic [PMAX:0] actual,
                             input logic [PMAX:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] ts,
                               input logic [KLEN_W-1:0] kl, input logic dv,
                               input logic [W-1:0] d, input logic dr);
    @(posedge clk);
    #1;
    start      = st;
    t_sel      = ts;
    k_len      = kl;
    din_valid  = dv;
    din        = d;
    dout_ready = dr;
  endtask

  function automatic logic [16:0] tb_min_poly(input int j);
    logic [16:0] tbl[12];
    tbl = '{17'h1002D, 17'h10173, 17'h10FBD, 17'h15A55, 17'h11F2F, 17'h1F7B5,
            17'h1AF65, 17'h17367, 17'h10EA1, 17'h175A7, 17'h13A2D, 17'h11AE3};
    return tbl[j-1];
  endfunction

  function automatic logic [192:0] tb_gen(input int t);
    logic [192:0] acc;
    logic [192:0] nxt;
    logic [16:0]  m;
    acc = 193'd1;
    for (int j = 1; j <= t; j++) begin
      m   = tb_min_poly(j);
      nxt = '0;
      for (int e = 0; e <= 16; e++) if (m[e]) nxt = nxt ^ (acc << e);
      acc = nxt;
    end
    return acc;
  endfunction

  // Long division of msg(x) * x^r by g(x).
  function automatic logic [191:0] model_parity(input int r);
    logic [192:0] g;
    logic [192:0] acc;
    logic         b;
    int           nmsg;
    g    = tb_gen(r / 16);
    acc  = '0;
    nmsg = msg.size() * 8;
    for (int i = 0; i < nmsg + r; i++) begin
      b = 1'b0;
      if (i < nmsg) b = msg[i / 8][7 - (i % 8)];
      acc = {acc[191:0], b};
      if (acc[r]) acc = acc ^ g;
    end
    return acc[191:0];
  endfunction

  task automatic build_frame(input int kind, input int klen, input int r,
                             output logic [191:0] par);
    int nw;
    nw = klen / 8;
    msg.delete();
    exp_word.delete();
    exp_de.delete();
    for (int i = 0; i < nw; i++) begin
      case (kind)
        K_ONE:   msg.push_back((i == nw - 1) ? 8'h01 : 8'h00);
        K_RAND:  msg.push_back(8'($urandom_range(0, 255)));
        default: msg.push_back(8'h00);
      endcase
      exp_word.push_back(msg[i]);
      exp_de.push_back(1'b1);
    end
    par = model_parity(r);
    for (int j = 0; j < r / 8; j++) begin
      exp_word.push_back(par[r - 1 - j * 8 -: 8]);
      exp_de.push_back(1'b0);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [191:0] par;
    logic [7:0]   hold_word;
    logic         hold_valid, dv, dr, st;
    int           nwd, widx, oidx, errs, pulses, busy_errs, cycles, limit;
    build_frame(v.kind, v.klen, v.exp_r, par);
    nwd = v.klen / 8;
    widx = 0; oidx = 0; errs = 0; pulses = 0; busy_errs = 0; cycles = 0;
    hold_valid = 1'b0;
    hold_word  = 8'h00;
    limit = v.exp_words * 20 + 100;
    applyStimulus(1'b1, v.tsel, KLEN_W'(v.klen), 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    while (pulses == 0 && cycles < limit) begin
      dv = (widx < nwd) && (v.bursty ? ($urandom_range(0, 3) != 0) : 1'b1);
      dr = v.slow ? ($urandom_range(0, 9) < 3) : 1'b1;
      st = v.inject && (widx == nwd / 2 || oidx == nwd + 1);
      applyStimulus(st, st ? 2'd0 : v.tsel, st ? KLEN_W'(8) : KLEN_W'(v.klen),
                    dv, dv ? msg[widx] : 8'h00, dr);
      @(negedge clk);
      cycles++;
      if (!busy && !parity_done) busy_errs++;
      if (hold_valid && (!dout_valid || dout !== hold_word)) errs++;
      hold_valid = dout_valid && !dout_ready;
      hold_word  = dout;
      if (din_valid && din_ready) widx++;
      if (dout_valid && dout_ready) begin
        if (oidx >= exp_word.size()) errs++;
        else if (dout !== exp_word[oidx] || dataenable !== exp_de[oidx]) errs++;
        oidx++;
      end
      if (parity_done) pulses++;
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, v.tsel, KLEN_W'(v.klen), 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      if (parity_done) pulses++;
      if (dout_valid) errs++;
    end
    checkOutput({tag, "_done_pulses"}, 193'(pulses), 193'(1));
    checkOutput({tag, "_out_words"}, 193'(oidx), 193'(v.exp_words));
    checkOutput({tag, "_in_words"}, 193'(widx), 193'(nwd));
    checkOutput({tag, "_stream_errs"}, 193'(errs), 193'(0));
    checkOutput({tag, "_busy_drop"}, 193'(busy_errs), 193'(0));
    checkOutput({tag, "_bits"}, 193'(bits), 193'(par));
    checkOutput({tag, "_idle_busy"}, 193'(busy), 193'(0));
  endtask

  task automatic reset_abort();
    logic [191:0] par;
    int           widx, cycles, pulses;
    build_frame(K_RAND, 16008, 192, par);
    widx = 0; cycles = 0; pulses = 0;
    applyStimulus(1'b1, 2'd2, KLEN_W'(16008), 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    while (widx < 1000 && cycles < 5000) begin
      applyStimulus(1'b0, 2'd2, KLEN_W'(16008), 1'b1, msg[widx], 1'b1);
      @(negedge clk);
      if (din_valid && din_ready) widx++;
      cycles++;
    end
    checkOutput("abort_reach_word1000", 193'(widx), 193'(1000));
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 193'(busy), 193'(0));
    checkOutput("abort_dout_valid", 193'(dout_valid), 193'(0));
    checkOutput("abort_bits_cleared", 193'(bits), 193'(0));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (parity_done) pulses++;
    end
    checkOutput("abort_no_parity_done", 193'(pulses), 193'(0));
  endtask

  initial begin
    logic [192:0] g12;
    reset      = 1'b0;
    start      = 1'b1;
    t_sel      = 2'd2;
    k_len      = KLEN_W'(64);
    din        = 8'h00;
    din_valid  = 1'b0;
    dout_ready = 1'b1;

    vecs[0] = '{2'd2, 16008, K_ZERO, 1'b0, 1'b0, 1'b0, 192, 2025};
    vecs[1] = '{2'd2,    64, K_ONE,  1'b0, 1'b0, 1'b0, 192,   32};
    vecs[2] = '{2'd0, 16008, K_RAND, 1'b0, 1'b0, 1'b0, 128, 2017};
    vecs[3] = '{2'd1,   800, K_RAND, 1'b1, 1'b1, 1'b0, 160,  120};
    vecs[4] = '{2'd3,   256, K_RAND, 1'b0, 1'b0, 1'b1, 192,   56};
    vecs[5] = '{2'd2,     0, K_ZERO, 1'b0, 1'b0, 1'b0, 192,   24};
    vecs[6] = '{2'd2, 16008, K_RAND, 1'b1, 1'b1, 1'b1, 192, 2025};
    vecs[7] = '{2'd1,  4000, K_RAND, 1'b1, 1'b1, 1'b0, 160,  520};

    // Reset asserted together with start: reset must win.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 193'(busy), 193'(0));
    checkOutput("reset_dout_valid", 193'(dout_valid), 193'(0));
    checkOutput("reset_din_ready", 193'(din_ready), 193'(0));
    checkOutput("reset_bits", 193'(bits), 193'(0));
    checkOutput("reset_parity_done", 193'(parity_done), 193'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v], $sformatf("vec%0d", v));
      if (v == 1) begin
        g12 = tb_gen(12);
        checkOutput("single_one_bits_eq_g", 193'(bits), {1'b0, g12[191:0]});
      end
    end

    reset_abort();
    run_frame(vecs[7], "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
